gate_sweep_ctrl: RTL and testbench
==================================

# gate_sweep_ctrl

Sequencer that exhaustively exercises one shared N-input logic gate (XNOR, AND, XOR, …) in-circuit. On a start request it walks the gate inputs through every binary combination and waits a programmable settle time per vector. It samples the gate output, builds the observed truth table and compares each sample against a golden function selected by an op code. It sits between the gate under test and the test/status logic, replacing hand-written per-vector stimulus.

## Interface
- N_IN, 2, number of gate inputs (1..4); the sweep covers 2^N_IN vectors
- SETTLE, 1, cycles each vector is held before its output is sampled (1..15)

- clk  in  1  single clock, rising edge
- reset  in  1  reset is asynchronous and active-high
- start  in  1  request a sweep; sampled only in IDLE
- op  in  3  golden function code, latched at start
- s  in  1  output of the gate under test
- vec  out  N_IN  registered drive to the gate inputs; vec[0] is the LSB input
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when a sweep completes
- pass  out  1  valid from done onward; 1 = zero mismatches
- table  out  2^N_IN  observed truth table; table[k] = s sampled while vec==k
- err_count  out  N_IN+1  number of mismatching vectors

## Operation
- States: IDLE, RUN, FIN.
- IDLE: busy=0. When start=1 at an edge:
  - latch op
  - clear table, err_count and pass
  - set vec=0 and settle counter=0
  - go to RUN
- RUN: busy=1.
  - Counter increments each edge.
  - At the edge where counter==SETTLE-1:
    - sample s into table[vec]
    - compare s against golden(op_latched, vec); a mismatch increments err_count
    - reset counter to 0
  - Then either:
    - if vec == 2^N_IN-1, go to FIN
    - otherwise vec increments
- FIN: lasts one cycle.
  - done=1, busy=0.
  - pass = (err_count==0), including the final compare.
  - Next edge goes to IDLE; vec returns to 0.
- Golden op codes:
  - 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR: reductions over all N_IN bits
  - 6 NOT (~vec[0]), 7 BUF (vec[0])
- err_count max is 2^N_IN and fits in N_IN+1 bits; no saturation is needed.
- table, err_count and pass hold their values after FIN until the next start.
- start in RUN or FIN is ignored; changes on op during a sweep are ignored.

## Timing
- Reset values of all outputs are 0: vec, busy, done, pass, table, err_count; state=IDLE.
- vec is registered. Vector k is driven from edge E0+k·SETTLE, where E0 is the start edge. It is sampled at edge E0+(k+1)·SETTLE.
- busy rises after E0. done is high during the cycle following edge E0+2^N_IN·SETTLE.
- Start-to-done latency is therefore 2^N_IN·SETTLE cycles; back-to-back sweeps need one IDLE cycle between them.
- The gate path from vec to s must settle within SETTLE cycles. SETTLE=1 means s is sampled one full cycle after vec changes.
- Reset asserted mid-sweep:
  - All outputs clear immediately, asynchronously; no done pulse is produced.
  - After release the block is in IDLE and awaits a new start.

## Structure
- Shared package gate_pkg:
  - op-code constants (OP_AND…OP_BUF)
  - the pure function golden(op, vec) used by RTL and bench alike
- One natural sub-module, sweep_counter: the settle counter plus vector index, with a terminal-count flag. The FSM and compare logic stay in gate_sweep_ctrl.

## Test plan
- N_IN=2, SETTLE=1, op=3, s driven by a real XNOR of vec:
  - vec steps 00,01,10,11
  - table=4'b1001, err_count=0, pass=1
  - done pulses 4 cycles after the start edge
- Same XNOR gate with op=0 (AND): table=4'b1001, err_count=1 (vector 00), pass=0.
- SETTLE=3, op=3: each vec value is held 3 cycles; done comes 12 cycles after start; results as in the first scenario.
- start re-pulsed and op changed to 1 mid-sweep: both ignored; exactly one done; results match the op latched at start.
- reset asserted while vec==2:
  - busy, vec, table and err_count read 0 at once; no done
  - a fresh start afterwards completes normally with pass=1
- N_IN=3, op=2 (XOR), s tied to 0: table=8'h00, err_count=4, pass=0; done 8 cycles after start.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared definitions for the gate sweep controller: op codes, FSM states and the
// golden reference function used to judge each sampled gate output.
package gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_XNOR = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    localparam int unsigned MAX_N_IN = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    // Expected gate output for input vector vec; only the low n_in bits take part.
    function automatic logic golden(input logic [2:0] op, input logic [MAX_N_IN-1:0] vec,
                                    input int unsigned n_in);
        logic [MAX_N_IN-1:0] mask;
        logic [MAX_N_IN-1:0] used;
        logic [MAX_N_IN-1:0] and_in;
        mask   = MAX_N_IN'((1 << n_in) - 1);
        used   = vec & mask;
        // Unused upper bits are forced high so they cannot spoil an AND reduction.
        and_in = vec | ~mask;
        case (op)
            OP_AND:  golden = &and_in;
            OP_OR:   golden = |used;
            OP_XOR:  golden = ^used;
            OP_XNOR: golden = ~^used;
            OP_NAND: golden = ~&and_in;
            OP_NOR:  golden = ~|used;
            OP_NOT:  golden = ~vec[0];
            default: golden = vec[0];
        endcase
    endfunction

endpackage

// File: rtl/sweep_counter.sv
// Settle-time counter plus vector index for the gate sweep; flags the sample
// cycle of each vector and the final vector of the sweep.
module sweep_counter #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clear_i,
    input  logic            en_i,
    output logic [N_IN-1:0] vec_o,
    output logic            tick_o,
    output logic            last_o
);

    localparam logic [3:0] CntMax = 4'(SETTLE - 1);

    logic [3:0]      cnt_q, cnt_d;
    logic [N_IN-1:0] vec_q, vec_d;

    assign vec_o  = vec_q;
    assign tick_o = (cnt_q == CntMax);
    assign last_o = (vec_q == {N_IN{1'b1}});

    always_comb begin
        cnt_d = cnt_q;
        vec_d = vec_q;
        if (clear_i) begin
            cnt_d = '0;
            vec_d = '0;
        end else if (en_i) begin
            if (tick_o) begin
                cnt_d = '0;
                // The last vector stays driven through the finish cycle.
                if (!last_o) begin
                    vec_d = vec_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            vec_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            vec_q <= vec_d;
        end
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// In-circuit exhaustive tester for one N-input gate: sweeps every input vector,
// records the observed truth table and counts mismatches against the golden op.
module gate_sweep_ctrl
    import gate_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [2:0]             op_i,
    input  logic                   s_i,
    output logic [N_IN-1:0]        vec_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic [(1<<N_IN)-1:0]   table_o,
    output logic [N_IN:0]          err_count_o
);

    localparam int unsigned NVec = 1 << N_IN;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [NVec-1:0] table_q, table_d;
    logic [N_IN:0]   err_q, err_d;
    logic            pass_q, pass_d;

    logic            cnt_clear;
    logic            cnt_en;
    logic [N_IN-1:0] vec;
    logic            tick;
    logic            last;

    sweep_counter #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_sweep_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .vec_o   (vec),
        .tick_o  (tick),
        .last_o  (last)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        table_d   = table_q;
        err_d     = err_q;
        pass_d    = pass_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d      = op_i;
                    table_d   = '0;
                    err_d     = '0;
                    pass_d    = 1'b0;
                    cnt_clear = 1'b1;
                    state_d   = StRun;
                end
            end
            StRun: begin
                cnt_en = 1'b1;
                if (tick) begin
                    table_d[vec] = s_i;
                    if (s_i != golden(op_q, MAX_N_IN'(vec), N_IN)) begin
                        err_d = err_q + 1'b1;
                    end
                    if (last) begin
                        // Verdict includes the compare made on this very edge.
                        pass_d  = (err_d == '0);
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                cnt_clear = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            op_q    <= '0;
            table_q <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            table_q <= table_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_o       = vec;
    assign busy_o      = (state_q == StRun);
    assign done_o      = (state_q == StFin);
    assign pass_o      = pass_q;
    assign table_o     = table_q;
    assign err_count_o = err_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench for gate_sweep_ctrl: three configurations, directed and random sweeps.
module tb_gate_sweep_ctrl;

    typedef struct {
        int         id;
        int         e0;
        logic [7:0] tab;
        logic [3:0] err;
        logic       pas;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] start = 3'b000;
    logic [2:0] op = 3'd0;
    logic [7:0] tt = 8'h00;

    logic [1:0] vec_a, vec_b;
    logic [2:0] vec_c;
    logic [3:0] tab_a, tab_b;
    logic [7:0] tab_c;
    logic [2:0] err_a, err_b;
    logic [3:0] err_c;
    logic       busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
    logic       s_a, s_b, s_c;

    logic [2:0] vw[3];
    logic [7:0] tw[3];
    logic [3:0] ew[3];
    logic       bw[3], dw[3], pw[3];

    int unsigned nin[3] = '{2, 2, 3};
    int unsigned st[3]  = '{1, 3, 1};

    exp_t       q[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] hold_t[3] = '{8'h00, 8'h00, 8'h00};
    logic [3:0] hold_e[3] = '{4'h0, 4'h0, 4'h0};
    logic       hold_p[3] = '{1'b0, 1'b0, 1'b0};
    exp_t       m_e;
    int         m_l;

    // Gate under test modelled as a truth-table lookup shared by whichever DUT is active.
    assign s_a = tt[vec_a];
    assign s_b = tt[vec_b];
    assign s_c = tt[vec_c];

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u_dut_a (
        .clk_i(clk), .reset_i(reset), .start_i(start[0]), .op_i(op), .s_i(s_a),
        .vec_o(vec_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
        .table_o(tab_a), .err_count_o(err_a)
    );

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(3)) u_dut_b (
        .clk_i(clk), .reset_i(reset), .start_i(start[1]), .op_i(op), .s_i(s_b),
        .vec_o(vec_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
        .table_o(tab_b), .err_count_o(err_b)
    );

    gate_sweep_ctrl #(.N_IN(3), .SETTLE(1)) u_dut_c (
        .clk_i(clk), .reset_i(reset), .start_i(start[2]), .op_i(op), .s_i(s_c),
        .vec_o(vec_c), .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c),
        .table_o(tab_c), .err_count_o(err_c)
    );

    always_comb begin
        vw[0] = {1'b0, vec_a};  vw[1] = {1'b0, vec_b};  vw[2] = vec_c;
        tw[0] = {4'h0, tab_a};  tw[1] = {4'h0, tab_b};  tw[2] = tab_c;
        ew[0] = {1'b0, err_a};  ew[1] = {1'b0, err_b};  ew[2] = err_c;
        bw[0] = busy_a; bw[1] = busy_b; bw[2] = busy_c;
        dw[0] = done_a; dw[1] = done_b; dw[2] = done_c;
        pw[0] = pass_a; pw[1] = pass_b; pw[2] = pass_c;
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk = n_chk + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, id, cyc, act, req);
        end
    endtask

    // Reference gate function from counting ones, independent of reduction operators.
    function automatic logic model_gold(input int o, input int k, input int n);
        int ones = 0;
        for (int b = 0; b < n; b++) if (((k >> b) & 1) == 1) ones++;
        case (o)
            0:       return ones == n;
            1:       return ones > 0;
            2:       return (ones % 2) == 1;
            3:       return (ones % 2) == 0;
            4:       return ones != n;
            5:       return ones == 0;
            6:       return (k % 2) == 0;
            default: return (k % 2) == 1;
        endcase
    endfunction

    function automatic logic [7:0] xnor_tt(input int n);
        logic [7:0] t = 8'h00;
        for (int k = 0; k < (1 << n); k++) t[k] = model_gold(3, k, n);
        return t;
    endfunction

    function automatic logic [7:0] gold_tt(input int o, input int n);
        logic [7:0] t = 8'h00;
        for (int k = 0; k < (1 << n); k++) t[k] = model_gold(o, k, n);
        return t;
    endfunction

    // Monitor: compares every DUT against the scoreboard front or its held results.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (q.size() > 0 && q[0].id == i) begin
                m_e = q[0];
                m_l = (1 << nin[i]) * st[i];
                chk("busy", i, 32'(bw[i]), 32'(cyc >= m_e.e0 && cyc < m_e.e0 + m_l));
                chk("done", i, 32'(dw[i]), 32'(cyc == m_e.e0 + m_l));
                if (cyc >= m_e.e0 && cyc < m_e.e0 + m_l)
                    chk("vec", i, 32'(vw[i]), 32'((cyc - m_e.e0) / int'(st[i])));
                if (cyc >= m_e.e0 + m_l) begin
                    chk("table", i, 32'(tw[i]), 32'(m_e.tab));
                    chk("err_count", i, 32'(ew[i]), 32'(m_e.err));
                    chk("pass", i, 32'(pw[i]), 32'(m_e.pas));
                    hold_t[i] = m_e.tab;
                    hold_e[i] = m_e.err;
                    hold_p[i] = m_e.pas;
                    void'(q.pop_front());
                end
            end else begin
                chk("idle_busy_done", i, {30'd0, bw[i], dw[i]}, 32'd0);
                chk("idle_vec", i, 32'(vw[i]), 32'd0);
                chk("hold_table", i, 32'(tw[i]), 32'(hold_t[i]));
                chk("hold_err", i, 32'(ew[i]), 32'(hold_e[i]));
                chk("hold_pass", i, 32'(pw[i]), 32'(hold_p[i]));
            end
        end
    end

    task automatic run_sweep(input int id, input int o, input logic [7:0] t,
                             input bit disturb, input int abort_vec);
        exp_t e;
        int   n;
        int   lat;
        n   = 1 << nin[id];
        lat = n * int'(st[id]);
        @(negedge clk);
        tt    = t;
        op    = 3'(o);
        e.id  = id;
        e.e0  = cyc + 1;
        e.tab = 8'h00;
        e.err = 4'h0;
        for (int k = 0; k < n; k++) begin
            e.tab[k] = t[k];
            if (t[k] != model_gold(o, k, int'(nin[id]))) e.err = e.err + 4'd1;
        end
        e.pas = (e.err == 4'h0);
        q.push_back(e);
        start[id] = 1'b1;
        @(negedge clk);
        start[id] = 1'b0;
        if (disturb) begin
            @(negedge clk);
            start[id] = 1'b1;
            op = 3'd1;
            @(negedge clk);
            start[id] = 1'b0;
        end
        if (abort_vec >= 0) begin
            for (int w = 0; w < lat + 4 && vw[id] != 3'(abort_vec); w++) @(negedge clk);
            #2 reset = 1'b1;
            #1;
            chk("rst_busy", id, 32'(bw[id]), 32'd0);
            chk("rst_vec", id, 32'(vw[id]), 32'd0);
            chk("rst_table", id, 32'(tw[id]), 32'd0);
            chk("rst_err", id, 32'(ew[id]), 32'd0);
            if (q.size() > 0) void'(q.pop_front());
            for (int i = 0; i < 3; i++) begin
                hold_t[i] = 8'h00;
                hold_e[i] = 4'h0;
                hold_p[i] = 1'b0;
            end
            @(negedge clk);
            #2 reset = 1'b0;
        end else begin
            for (int w = 0; w < lat + 4 && q.size() > 0; w++) @(negedge clk);
            if (q.size() > 0) begin
                chk("done_timeout", id, 32'(q.size()), 32'd0);
                void'(q.pop_front());
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int id;
        int o;
        logic [7:0] t;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++)
            chk("reset_state", i, {18'd0, vw[i], tw[i], ew[i], bw[i], dw[i], pw[i]}, 32'd0);

        run_sweep(0, 3, xnor_tt(2), 1'b0, -1);   // XNOR vs XNOR: pass
        run_sweep(0, 0, xnor_tt(2), 1'b0, -1);   // XNOR vs AND: one mismatch
        run_sweep(1, 3, xnor_tt(2), 1'b0, -1);   // SETTLE=3
        run_sweep(0, 3, xnor_tt(2), 1'b1, -1);   // start and op disturbed mid-sweep
        run_sweep(0, 3, xnor_tt(2), 1'b0, 2);    // reset while vec==2
        run_sweep(0, 3, xnor_tt(2), 1'b0, -1);   // fresh sweep after reset
        run_sweep(2, 2, 8'h00, 1'b0, -1);        // XOR vs stuck-at-0

        for (int r = 0; r < 24; r++) begin
            id = int'($urandom_range(0, 2));
            o  = int'($urandom_range(0, 7));
            t  = 8'($urandom);
            if ($urandom_range(0, 2) == 0) t = gold_tt(o, int'(nin[id]));
            run_sweep(id, o, t, ($urandom_range(0, 3) == 0), -1);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
